// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: synchronizes SCK/MOSI/nSS into clk, shifts 8-bit MSB-first
// frames, and exposes RX status and TX buffering through a strobe/ack bus port.
module spi_slave_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        cmd,
  input  logic        wr,
  input  logic        rd,
  output logic [10:0] dout,
  output logic        ack,
  output logic        irq,
  input  logic        SPI_SCK,
  input  logic        SPI_MOSI,
  input  logic        SPI_nSS,
  output logic        SPI_MISO,
  output logic        SPI_MISO_OE
);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_nss_sync;
  logic                   r_sck_d;
  logic                   r_nss_d;
  logic [1:0]             r_ctrl;
  logic [7:0]             r_txbuf;
  logic [7:0]             r_tx_shr;
  logic [7:0]             r_rx_shr;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_rxdata;
  logic                   r_rxv;
  logic                   r_ovr;
  logic                   r_ack;

  logic w_sck, w_mosi, w_nss;
  logic w_sck_rise, w_sck_fall, w_nss_rise, w_nss_fall;
  logic w_cmd, w_wr, w_rd, w_busy;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_nss      = r_nss_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_nss_rise = w_nss & ~r_nss_d;
  assign w_nss_fall = ~w_nss & r_nss_d;

  // Overlapping strobes resolve as cmd > wr > rd
  assign w_cmd  = cmd;
  assign w_wr   = wr & ~cmd;
  assign w_rd   = rd & ~cmd & ~wr;
  assign w_busy = (r_state == S_XFER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_nss_sync  <= '1;
      r_sck_d     <= 1'b0;
      r_nss_d     <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SPI_SCK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], SPI_nSS};
      r_sck_d     <= w_sck;
      r_nss_d     <= w_nss;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ctrl    <= '0;
      r_txbuf   <= '0;
      r_tx_shr  <= '0;
      r_rx_shr  <= '0;
      r_bit_cnt <= '0;
      r_rxdata  <= '0;
      r_rxv     <= 1'b0;
      r_ovr     <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= cmd | wr | rd;
      if (w_cmd) r_ctrl  <= din[1:0];
      if (w_wr)  r_txbuf <= din;
      if (w_rd) begin
        r_rxv <= 1'b0;
        r_ovr <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_nss_fall && r_ctrl[0]) begin
            r_state   <= S_XFER;
            r_tx_shr  <= r_txbuf;
            r_bit_cnt <= '0;
          end
        end
        S_XFER: begin
          if (w_nss_rise || (w_cmd && !din[0])) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
          end else if (w_sck_rise) begin
            r_rx_shr  <= {r_rx_shr[6:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            // Byte completion overrides a coincident rd: RXV stays set, OVR clears
            if (r_bit_cnt == 3'd7) begin
              r_rxdata <= {r_rx_shr[6:0], w_mosi};
              r_rxv    <= 1'b1;
              r_ovr    <= w_rd ? 1'b0 : (r_ovr | r_rxv);
            end
          end else if (w_sck_fall) begin
            if (r_bit_cnt == 3'd0) r_tx_shr <= r_txbuf;
            else                   r_tx_shr <= {r_tx_shr[6:0], 1'b0};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout        = {w_busy, r_ovr, r_rxv, r_rxdata};
  assign ack         = r_ack;
  assign irq         = r_ctrl[1] & r_rxv;
  assign SPI_MISO    = w_busy & r_tx_shr[7];
  assign SPI_MISO_OE = w_busy;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a mode-0 master model at f_clk/8 plus bus strobes.
module tb_spi_slave_if;

  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        cmd, wr, rd;
  logic [10:0] dout;
  logic        ack, irq;
  logic        sck, mosi, nss;
  logic        miso, miso_oe;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] got;

  always #5 clk = ~clk;

  spi_slave_if #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .din(din), .cmd(cmd), .wr(wr), .rd(rd),
    .dout(dout), .ack(ack), .irq(irq),
    .SPI_SCK(sck), .SPI_MOSI(mosi), .SPI_nSS(nss),
    .SPI_MISO(miso), .SPI_MISO_OE(miso_oe)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind: 0=cmd 1=wr 2=rd; checks the one-cycle ack pulse
  task automatic bus_op(input int kind, input logic [7:0] d, input string tag);
    @(negedge clk);
    din = d;
    cmd = (kind == 0);
    wr  = (kind == 1);
    rd  = (kind == 2);
    @(negedge clk);
    cmd = 1'b0; wr = 1'b0; rd = 1'b0;
    chk({tag, "_ack1"}, {15'd0, ack}, 16'd1);
    @(negedge clk);
    chk({tag, "_ack0"}, {15'd0, ack}, 16'd0);
  endtask

  // Mode-0 master: MOSI set while SCK low, MISO sampled just before each rising edge.
  // Optional wr mid bit 3, optional rd aligned to the clk cycle where the 8th edge completes.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit do_wr,
                          input logic [7:0] wdata, input bit rd_done, output logic [7:0] rxm);
    rxm = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(HALF);
      rxm = {rxm[6:0], miso};
      sck = 1'b1;
      if (do_wr && i == 3) begin
        wait_clk(1);
        din = wdata; wr = 1'b1;
        wait_clk(1);
        wr = 1'b0;
        wait_clk(HALF - 2);
      end else if (rd_done && i == 7) begin
        wait_clk(SYNC);
        rd = 1'b1;
        wait_clk(1);
        rd = 1'b0;
        wait_clk(HALF - SYNC - 1);
      end else begin
        wait_clk(HALF);
      end
      sck = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; din = '0; cmd = 0; wr = 0; rd = 0;
    sck = 1'b0; mosi = 1'b0; nss = 1'b1;
    wait_clk(3);
    chk("rst_dout", {5'd0, dout}, 16'h000);
    chk("rst_ack",  {15'd0, ack}, 16'd0);
    chk("rst_irq",  {15'd0, irq}, 16'd0);
    chk("rst_oe",   {15'd0, miso_oe}, 16'd0);
    chk("rst_miso", {15'd0, miso}, 16'd0);
    rst = 1'b0;
    wait_clk(2);

    // Basic frame: EN+IRQ_EN, send A5 while receiving 3C
    bus_op(0, 8'h03, "cmd03");
    bus_op(1, 8'hA5, "wrA5");
    nss = 1'b0;
    wait_clk(8);
    chk("t2_oe", {15'd0, miso_oe}, 16'd1);
    spi_bits(8'h3C, 8, 0, 8'h00, 0, got);
    chk("t2_miso", {8'd0, got}, 16'h00A5);
    wait_clk(HALF);
    chk("t2_dout_busy", {5'd0, dout}, 16'h053C);
    chk("t2_irq", {15'd0, irq}, 16'd1);
    nss = 1'b1;
    wait_clk(6);
    chk("t2_dout_idle", {5'd0, dout}, 16'h013C);
    chk("t2_oe_idle", {15'd0, miso_oe}, 16'd0);
    bus_op(2, 8'h00, "rd1");
    chk("t2_dout_rd", {5'd0, dout}, 16'h003C);
    chk("t2_irq_rd", {15'd0, irq}, 16'd0);

    // Back-to-back bytes without rd: overrun, TX underrun repeats A5
    nss = 1'b0;
    wait_clk(8);
    spi_bits(8'h11, 8, 0, 8'h00, 0, got);
    chk("t3_miso1", {8'd0, got}, 16'h00A5);
    spi_bits(8'h22, 8, 0, 8'h00, 0, got);
    chk("t3_miso2", {8'd0, got}, 16'h00A5);
    wait_clk(HALF);
    chk("t3_dout_ovr", {5'd0, dout}, 16'h0722);
    nss = 1'b1;
    wait_clk(6);
    bus_op(2, 8'h00, "rd2");
    chk("t3_dout_rd", {5'd0, dout}, 16'h0022);

    // wr 5A during byte 1 feeds byte 2; rd coincident with byte-2 completion
    nss = 1'b0;
    wait_clk(8);
    spi_bits(8'h11, 8, 1, 8'h5A, 0, got);
    chk("t4_miso1", {8'd0, got}, 16'h00A5);
    spi_bits(8'h22, 8, 0, 8'h00, 1, got);
    chk("t4_miso2", {8'd0, got}, 16'h005A);
    wait_clk(HALF);
    chk("t4_dout_rdwin", {5'd0, dout}, 16'h0522);
    nss = 1'b1;
    wait_clk(6);
    bus_op(2, 8'h00, "rd3");
    chk("t4_dout_rd", {5'd0, dout}, 16'h0022);

    // Aborted partial frame, then a full frame proves bit_cnt was cleared
    nss = 1'b0;
    wait_clk(8);
    spi_bits(8'hF8, 5, 0, 8'h00, 0, got);
    wait_clk(HALF);
    nss = 1'b1;
    wait_clk(6);
    chk("t5_dout_abort", {5'd0, dout}, 16'h0022);
    chk("t5_oe_abort", {15'd0, miso_oe}, 16'd0);
    nss = 1'b0;
    wait_clk(8);
    spi_bits(8'h81, 8, 0, 8'h00, 0, got);
    chk("t5_miso", {8'd0, got}, 16'h005A);
    wait_clk(HALF);
    chk("t5_dout", {5'd0, dout}, 16'h0581);
    nss = 1'b1;
    wait_clk(6);
    bus_op(2, 8'h00, "rd4");

    // EN=0 ignores the frame; enabling mid-frame must wait for a new nSS fall
    bus_op(0, 8'h00, "cmd00");
    nss = 1'b0;
    wait_clk(8);
    chk("t6_oe_dis", {15'd0, miso_oe}, 16'd0);
    spi_bits(8'hFF, 4, 0, 8'h00, 0, got);
    bus_op(0, 8'h01, "cmd01");
    spi_bits(8'hFF, 4, 0, 8'h00, 0, got);
    wait_clk(6);
    chk("t6_oe_mid", {15'd0, miso_oe}, 16'd0);
    chk("t6_dout_mid", {5'd0, dout}, 16'h0081);
    nss = 1'b1;
    wait_clk(6);
    nss = 1'b0;
    wait_clk(8);
    chk("t6_oe_new", {15'd0, miso_oe}, 16'd1);
    spi_bits(8'hFF, 8, 0, 8'h00, 0, got);
    wait_clk(HALF);
    chk("t6_dout_new", {5'd0, dout}, 16'h05FF);
    chk("t6_irq_off", {15'd0, irq}, 16'd0);
    nss = 1'b1;
    wait_clk(6);
    bus_op(2, 8'h00, "rd5");

    // Asynchronous reset during bit 4 of a frame
    nss = 1'b0;
    wait_clk(8);
    spi_bits(8'hC3, 4, 0, 8'h00, 0, got);
    chk("t1_busy_pre", {15'd0, dout[10]}, 16'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t1_dout_async", {5'd0, dout}, 16'h000);
    chk("t1_oe_async", {15'd0, miso_oe}, 16'd0);
    chk("t1_miso_async", {15'd0, miso}, 16'd0);
    chk("t1_ack_async", {15'd0, ack}, 16'd0);
    chk("t1_irq_async", {15'd0, irq}, 16'd0);
    nss = 1'b1; sck = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(6);
    chk("t1_oe_after", {15'd0, miso_oe}, 16'd0);
    chk("t1_dout_after", {5'd0, dout}, 16'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
